// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Receives device-to-host PS/2 frames (scan code set 2) and converts the
// make/break codes of five game keys into held-key levels.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock (asynchronous)
//   ps2_data   in   raw PS/2 data (asynchronous)
//   raw_left   out  high while E0 6B (left arrow) is held
//   raw_right  out  high while E0 74 (right arrow) is held
//   raw_down   out  high while E0 72 (down arrow) is held
//   raw_rotate out  high while E0 75 (up arrow) is held
//   raw_drop   out  high while 29 (space) is held
//   scan_code  out  last good byte received
//   scan_valid out  one-cycle pulse per good byte
//   frame_err  out  one-cycle pulse per bad frame (parity/stop error)
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate,
  output logic       raw_drop,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchroniser stages (lines idle high, so they reset high)
  logic          clk_p0, clk_p1;
  logic          data_p0, data_p1;

  // Clock filter
  logic          filt, filt_d;
  logic [FW-1:0] fcnt;
  logic          fe;

  // Frame FSM
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt;
  logic          good, bad;

  // Prefix flags
  logic          ext, brk;

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // Filter: the level follows clk_p1 only after FILTER_LEN consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_p1 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        filt <= clk_p1;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fe = filt_d & ~filt;

  // Frame state register and bit-level datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
    end
  end

  // Idle-time counter: only runs mid-frame, restarted by every falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == IDLE || fe) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    good      = 1'b0;
    bad       = 1'b0;
    if (state != IDLE && !fe && tcnt == TMAX) begin
      // Abandoned frame: silent return, prefixes untouched
      state_n = IDLE;
    end else if (fe) begin
      case (state)
        IDLE: begin
          if (!data_p1) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shreg_n = {data_p1, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          par_n   = data_p1;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          // Odd parity over data+parity and a high stop bit
          if (data_p1 && (^{shreg, par})) begin
            good = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p2: byte decode, all outputs update on the stop-bit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      raw_left   <= 1'b0;
      raw_right  <= 1'b0;
      raw_down   <= 1'b0;
      raw_rotate <= 1'b0;
      raw_drop   <= 1'b0;
    end else begin
      scan_valid <= good;
      frame_err  <= bad;
      if (bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (good) begin
        scan_code <= shreg;
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (shreg == 8'hAA && !ext && !brk) begin
          // Keyboard self-test completion: drop every held key
          raw_left   <= 1'b0;
          raw_right  <= 1'b0;
          raw_down   <= 1'b0;
          raw_rotate <= 1'b0;
          raw_drop   <= 1'b0;
        end else begin
          if (ext) begin
            case (shreg)
              8'h6B:   raw_left   <= !brk;
              8'h74:   raw_right  <= !brk;
              8'h72:   raw_down   <= !brk;
              8'h75:   raw_rotate <= !brk;
              default: ;
            endcase
          end else if (shreg == 8'h29) begin
            raw_drop <= !brk;
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the PS/2 keyboard serial stream (device-to-host frames, scan code set 2) and turns make/break codes into held-key levels `raw_left`, `raw_right`, `raw_down`, `raw_rotate`, `raw_drop`. These levels feed `input_manager`, which applies one-shot and auto-repeat (DAS) shaping. The block sits between the board PS/2 pins and `input_manager`. It synchronises and filters the PS/2 lines, deframes bytes, tracks E0/F0 prefixes, and exposes each received byte for debug.

## Interface
- `FILTER_LEN`, 8: consecutive identical `clk` samples needed before filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles mid-frame before the frame is abandoned (1 ms at 100 MHz).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `raw_left` out 1: level, high while E0 6B (left arrow) is held.
- `raw_right` out 1: level, high while E0 74 (right arrow) is held.
- `raw_down` out 1: level, high while E0 72 (down arrow) is held.
- `raw_rotate` out 1: level, high while E0 75 (up arrow) is held.
- `raw_drop` out 1: level, high while 29 (space) is held.
- `scan_code` out 8: last good byte received; holds its value between frames.
- `scan_valid` out 1: one-cycle pulse for each good byte.
- `frame_err` out 1: one-cycle pulse for each bad frame (parity or stop error).

## Operation
- **Input sync:** 2-flop synchroniser on each PS/2 line. The synchronised `ps2_clk` goes through a saturating counter filter: the filtered level changes only after `FILTER_LEN` consecutive samples at the new value.
- **Falling-edge strobe `fe`:** the filtered clock was 1 last cycle and is 0 this cycle. Synchronised `ps2_data` is sampled only in `fe` cycles.
- **Frame FSM**
  - IDLE: on `fe` with data 0 (start bit), go to DATA with bit count 0. On `fe` with data 1, stay in IDLE and produce no error.
  - DATA: shift the byte in LSB first. After 8 bits, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on `fe`, the frame is good if data is 1 and the 8 data bits plus the parity bit have an odd number of ones. Otherwise it is bad. Go to IDLE in both cases.
- **Timeout:** in any state other than IDLE, a cycle counter counts up and clears on each `fe`. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE. A timeout gives no `frame_err` and leaves the prefix flags unchanged.
- **Byte decode (good byte):**
  - E0 sets `ext`.
  - F0 sets `brk`.
  - AA with both flags clear is the keyboard self-test: all `raw_*` go to 0.
  - Any other byte: if the code (together with `ext`) matches a mapped key, that key's level is set to `!brk`. Then `ext` and `brk` are both cleared, including for unmapped codes.
  - Extended codes need `ext=1`. Non-extended 6B, 74, 72, 75 (keypad) do not affect the outputs. Space (29) needs `ext=0`.
- **Bad frame:** discard the byte, pulse `frame_err`, clear `ext` and `brk`. The `raw_*` levels are unchanged.
- Keys are independent. Any combination can be high at once.

## Timing
- Reset values: all `raw_*`, `scan_valid`, `frame_err` = 0; `scan_code` = 00; FSM in IDLE; `ext` = `brk` = 0; counters = 0.
- Input latency: a `ps2_clk` edge becomes `fe` 2 sync cycles + `FILTER_LEN` cycles later, ±1 cycle.
- The stop-bit `fe` cycle is T. At the clock edge ending cycle T, `scan_code`, `scan_valid` (or `frame_err`), the prefix flags and `raw_*` all update together. They are visible in T+1.
- `scan_valid` and `frame_err` stay high for exactly one cycle and are never high in the same cycle.
- `rst` mid-frame: everything returns to reset values immediately. The next start bit after reset release starts a clean frame.
- A filter glitch shorter than `FILTER_LEN` cycles produces no `fe`.

## Test plan
Bench settings: `FILTER_LEN`=4, `TIMEOUT_CYCLES`=2000, PS/2 bit half-period 100 `clk` cycles.
1. **Arrow make/break.** Send E0, 6B → `scan_valid` pulses twice, `scan_code`=6B, `raw_left`=1. Then send E0, F0, 6B → `raw_left`=0. All other `raw_*` stay 0 throughout.
2. **Overlapping keys.** Hold E0 75, then send 29 → `raw_rotate`=1 and `raw_drop`=1. Send F0 29 → `raw_drop`=0 while `raw_rotate` stays 1. Send AA → all `raw_*` = 0.
3. **Keypad code.** Send non-extended 6B and 72 → `scan_valid` pulses for each, but `raw_left` and `raw_down` stay 0.
4. **Parity error clears prefix.** Send E0, then 75 with the parity bit inverted → `frame_err` pulses once and there is no `scan_valid` for that frame. Then send 75 → `raw_rotate` stays 0.
5. **Timeout, then recovery.** Send a start bit plus 4 data bits, then hold `ps2_clk` high for more than 2000 cycles → no pulses. Then send a full 29 frame → `raw_drop`=1.
6. **Glitch and mid-frame reset.** A 2-cycle low glitch on `ps2_clk` produces no bit, and the following frame decodes correctly. Assert `rst` during bit 5 of E0 74 → all outputs are 0. Then send E0 74 → `raw_right`=1.
